// File: rtl/cordic_sequencer.sv
// cordic_sequencer: iterative rotation-mode CORDIC controller.
// Runs ITERATIONS micro-rotations, two per clock, on a two-stage
// combinational cordic_chain, and holds the x/y/z working registers,
// the even-valued stage counter and the arctangent ROM.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 level-sampled run request (IDLE only)
//   x_in, y_in, z_in      signed operands; z in Q3.24 radians, |z| <= pi/2
//   busy                  high in RUN and DONE
//   done                  one-cycle pulse, results valid in that cycle
//   x_out, y_out, z_out   working registers (held until next start)

// cordic_chain: two back-to-back rotation-mode micro-rotations with shift
// amounts `stages` and `stages+1`. Purely combinational.
//
// Ports:
//   stages                shift for the first micro-rotation
//   atan0, atan1          angle constants for the two micro-rotations
//   x_i, y_i, z_i         incoming vector and residual angle
//   x_o, y_o, z_o         vector and residual after both micro-rotations
module cordic_chain (
    input  logic        [4:0]  stages,
    input  logic signed [26:0] atan0,
    input  logic signed [26:0] atan1,
    input  logic signed [26:0] x_i,
    input  logic signed [26:0] y_i,
    input  logic signed [26:0] z_i,
    output logic signed [26:0] x_o,
    output logic signed [26:0] y_o,
    output logic signed [26:0] z_o
);
    logic        [4:0]  stages1;
    logic signed [26:0] x_m, y_m, z_m;

    assign stages1 = stages + 5'd1;

    // Rotate towards zero residual: non-negative z rotates counter-clockwise.
    always_comb begin
        if (z_i[26]) begin
            x_m = x_i + (y_i >>> stages);
            y_m = y_i - (x_i >>> stages);
            z_m = z_i + atan0;
        end else begin
            x_m = x_i - (y_i >>> stages);
            y_m = y_i + (x_i >>> stages);
            z_m = z_i - atan0;
        end
    end

    always_comb begin
        if (z_m[26]) begin
            x_o = x_m + (y_m >>> stages1);
            y_o = y_m - (x_m >>> stages1);
            z_o = z_m + atan1;
        end else begin
            x_o = x_m - (y_m >>> stages1);
            y_o = y_m + (x_m >>> stages1);
            z_o = z_m - atan1;
        end
    end
endmodule

module cordic_sequencer #(
    parameter int ITERATIONS = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [26:0] x_in,
    input  logic signed [26:0] y_in,
    input  logic signed [26:0] z_in,
    output logic               busy,
    output logic               done,
    output logic signed [26:0] x_out,
    output logic signed [26:0] y_out,
    output logic signed [26:0] z_out
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Counter value applied on the final RUN edge.
    localparam logic [4:0] LAST_CNT = 5'(ITERATIONS - 2);

    // round(atan(2^-i) * 2^24)
    localparam logic signed [26:0] ATAN_ROM [0:19] = '{
        27'sd13176795, 27'sd7778716, 27'sd4110060, 27'sd2086331,
        27'sd1047214,  27'sd524117,  27'sd262123,  27'sd131069,
        27'sd65536,    27'sd32768,   27'sd16384,   27'sd8192,
        27'sd4096,     27'sd2048,    27'sd1024,    27'sd512,
        27'sd256,      27'sd128,     27'sd64,      27'sd32
    };

    state_t             state_q, state_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic signed [26:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [26:0] x_c, y_c, z_c;
    logic        [4:0]  cnt_p1;

    // cnt_q is even and at most 18 in RUN, so cnt_q+1 stays within the ROM.
    assign cnt_p1 = cnt_q + 5'd1;

    cordic_chain u_chain (
        .stages (cnt_q),
        .atan0  (ATAN_ROM[cnt_q]),
        .atan1  (ATAN_ROM[cnt_p1]),
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .x_o    (x_c),
        .y_o    (y_c),
        .z_o    (z_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    // Next state and working-register updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = z_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                x_d   = x_c;
                y_d   = y_c;
                z_d   = z_c;
                cnt_d = cnt_q + 5'd2;
                if (cnt_q == LAST_CNT) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;
endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: a 20-iteration and a
// 2-iteration instance, checked against a floating-point-derived
// angle table and a plain iterative CORDIC reference loop.
module tb_cordic_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start_a = 1'b0, start_b = 1'b0;
    logic signed [26:0] xa_in = '0, ya_in = '0, za_in = '0;
    logic signed [26:0] xb_in = '0, yb_in = '0, zb_in = '0;
    logic               busy_a, done_a, busy_b, done_b;
    logic signed [26:0] xa_out, ya_out, za_out, xb_out, yb_out, zb_out;

    cordic_sequencer #(.ITERATIONS(20)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .x_in(xa_in), .y_in(ya_in), .z_in(za_in),
        .busy(busy_a), .done(done_a),
        .x_out(xa_out), .y_out(ya_out), .z_out(za_out)
    );

    cordic_sequencer #(.ITERATIONS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .x_in(xb_in), .y_in(yb_in), .z_in(zb_in),
        .busy(busy_b), .done(done_b),
        .x_out(xb_out), .y_out(yb_out), .z_out(zb_out)
    );

    int n_chk = 0;
    int n_err = 0;
    int sel = 0;
    int rom[20];

    logic               busy_m, done_m;
    logic signed [26:0] x_m, y_m, z_m;

    always_comb begin
        if (sel == 1) begin
            busy_m = busy_b; done_m = done_b;
            x_m = xb_out; y_m = yb_out; z_m = zb_out;
        end else begin
            busy_m = busy_a; done_m = done_a;
            x_m = xa_out; y_m = ya_out; z_m = za_out;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: n sequential micro-rotations, 27-bit wrapping arithmetic.
    task automatic model(input int n, input logic signed [26:0] xi, yi, zi,
                         output logic signed [26:0] xo, yo, zo);
        logic signed [26:0] x, y, z, xt, a;
        x = xi; y = yi; z = zi;
        for (int i = 0; i < n; i++) begin
            a = rom[i][26:0];
            if (z >= 0) begin
                xt = x - (y >>> i); y = y + (x >>> i); z = z - a;
            end else begin
                xt = x + (y >>> i); y = y - (x >>> i); z = z + a;
            end
            x = xt;
        end
        xo = x; yo = y; zo = z;
    endtask

    task automatic drive(input bit st, input logic signed [26:0] x, y, z);
        if (sel == 1) begin
            start_b = st; xb_in = x; yb_in = y; zb_in = z;
        end else begin
            start_a = st; xa_in = x; ya_in = y; za_in = z;
        end
    endtask

    // One start pulse; checks busy, latency, single-cycle done, results.
    // meddle: pulse start with altered operands mid-run and in the done cycle.
    task automatic run(input int s, input logic signed [26:0] xi, yi, zi,
                       input bit meddle, input string tag);
        int n;
        int lat;
        bit seen;
        logic signed [26:0] ex, ey, ez;
        n = (s == 1) ? 2 : 20;
        lat = 0;
        seen = 0;
        sel = s;
        model(n, xi, yi, zi, ex, ey, ez);
        @(negedge clk);
        drive(1'b1, xi, yi, zi);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, xi, yi, zi);
        chk({tag, "_busy_e0"}, busy_m, 1);
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_m) begin
                seen = 1;
                lat = k;
            end else begin
                chk({tag, "_busy_run"}, busy_m, 1);
                if (meddle && k == 2) drive(1'b1, ~xi, yi + 27'sd12345, -zi);
                if (meddle && k == 3) drive(1'b0, ~xi, yi + 27'sd12345, -zi);
            end
        end
        chk({tag, "_latency"}, lat, n / 2);
        chk({tag, "_busy_done"}, busy_m, 1);
        chk({tag, "_x"}, x_m, ex);
        chk({tag, "_y"}, y_m, ey);
        chk({tag, "_z"}, z_m, ez);
        if (meddle) drive(1'b1, ~xi, yi, zi);
        @(negedge clk);
        drive(1'b0, xi, yi, zi);
        chk({tag, "_done_pulse"}, done_m, 0);
        chk({tag, "_busy_idle"}, busy_m, 0);
        chk({tag, "_x_hold"}, x_m, ex);
        @(negedge clk);
        chk({tag, "_no_requeue"}, busy_m, 0);
        chk({tag, "_z_hold"}, z_m, ez);
    endtask

    initial begin
        int q[$];
        int dones;
        logic signed [26:0] rx, ry, rz, ex, ey, ez;

        for (int i = 0; i < 20; i++)
            rom[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 16777216.0 + 0.5);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_x_a", xa_out, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_z_b", zb_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed angles
        run(0, 27'sd10188013, 27'sd0, 27'sd0, 1'b0, "zero");
        chk("zero_x_tol", absl(longint'(x_m) - 16777216) <= 256, 1);
        chk("zero_y_tol", absl(longint'(y_m)) <= 256, 1);
        chk("zero_z_tol", absl(longint'(z_m)) <= 64, 1);

        run(0, 27'sd10188013, 27'sd0, 27'sd13176795, 1'b0, "pi4");
        chk("pi4_x_tol", absl(longint'(x_m) - 11863283) <= 256, 1);
        chk("pi4_y_tol", absl(longint'(y_m) - 11863283) <= 256, 1);

        run(0, 27'sd10188013, 27'sd0, -27'sd13176795, 1'b0, "neg");
        chk("neg_x_tol", absl(longint'(x_m) - 11863283) <= 256, 1);
        chk("neg_y_tol", absl(longint'(y_m) + 11863283) <= 256, 1);

        // Start while busy and operand changes mid-run
        run(0, 27'sd5000000, -27'sd3000000, 27'sd9000000, 1'b1, "meddle");

        // Short run
        run(1, 27'sd10188013, 27'sd0, 27'sd13176795, 1'b0, "short");

        // Randomized runs on both instances
        for (int r = 0; r < 24; r++) begin
            rx = 27'(int'($urandom_range(0, 33554431)) - 16777216);
            ry = 27'(int'($urandom_range(0, 33554431)) - 16777216);
            rz = 27'(int'($urandom_range(0, 52707178)) - 26353589);
            run(r % 2, rx, ry, rz, 1'b0, "rand");
        end

        // Continuous start: back-to-back runs
        sel = 0;
        rx = 27'sd7000000; ry = 27'sd1000000; rz = -27'sd20000000;
        model(20, rx, ry, rz, ex, ey, ez);
        @(negedge clk);
        drive(1'b1, rx, ry, rz);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_m) begin
                q.push_back(c);
                chk("cont_x", x_m, ex);
                chk("cont_y", y_m, ey);
            end
        end
        drive(1'b0, rx, ry, rz);
        chk("cont_count_ok", q.size() >= 4, 1);
        for (int i = 1; i < q.size(); i++)
            chk("cont_period", q[i] - q[i-1], 12);
        repeat (15) @(negedge clk);
        chk("cont_idle", busy_m, 0);

        // Reset mid-run
        sel = 0;
        drive(1'b1, 27'sd9000000, 27'sd2000000, 27'sd3000000);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 27'sd9000000, 27'sd2000000, 27'sd3000000);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_x", xa_out, 0);
        chk("midrst_y", ya_out, 0);
        chk("midrst_z", za_out, 0);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run(0, 27'sd10188013, 27'sd0, 27'sd4000000, 1'b0, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
